// File: rtl/fifo_read_stage_if.sv
// Handshake/bus bundle between the FIFO read stage, the FIFO core and the consumer.
interface fifo_read_stage_if #(
  parameter int unsigned WIDTH = 8
);
  logic             empty;
  logic             ren;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       level;

  // Read stage side: consumes FIFO flags/data and consumer ready, drives the rest.
  modport master (
    input  empty,
    input  rd_data,
    input  out_ready,
    output ren,
    output out_data,
    output out_valid,
    output level
  );

  // FIFO core / consumer side.
  modport slave (
    output empty,
    output rd_data,
    output out_ready,
    input  ren,
    input  out_data,
    input  out_valid,
    input  level
  );
endinterface

// File: rtl/fifo_read_stage.sv
// FIFO read output stage: issues read enables against a 1-cycle-latency RAM
// and buffers returning words in a 2-entry skid buffer for a valid/ready consumer.
module fifo_read_stage #(
  parameter int unsigned WIDTH = 8
) (
  input  logic              clock,
  input  logic              reset,
  fifo_read_stage_if.master bus
);

  localparam int unsigned CNT_W = 2;
  localparam int unsigned SUM_W = 3;

  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             r_inflight;

  logic             w_pop;
  logic             w_ren;
  logic [SUM_W-1:0] w_pending;
  logic [SUM_W-1:0] w_budget;
  logic [CNT_W-1:0] w_count_post;
  logic [CNT_W-1:0] w_count_nxt;
  logic [WIDTH-1:0] w_head_nxt;
  logic [WIDTH-1:0] w_tail_nxt;

  // Read issue: buffered plus in-flight words may not exceed one slot plus this cycle's pop credit.
  always_comb begin
    w_pop     = (r_count != CNT_W'(0)) & bus.out_ready;
    w_pending = SUM_W'(r_count) + SUM_W'(r_inflight);
    w_budget  = SUM_W'(1) + SUM_W'(w_pop);
    w_ren     = ~reset & ~bus.empty & (w_pending <= w_budget);
  end

  // Buffer update: pop shifts tail to head, then the returning word lands in the first free slot.
  always_comb begin
    w_head_nxt   = r_head;
    w_tail_nxt   = r_tail;
    w_count_post = r_count - CNT_W'(w_pop);
    if (w_pop && (r_count == CNT_W'(2))) begin
      w_head_nxt = r_tail;
    end
    if (r_inflight) begin
      if (w_count_post == CNT_W'(0)) begin
        w_head_nxt = bus.rd_data;
      end else begin
        w_tail_nxt = bus.rd_data;
      end
    end
    w_count_nxt = w_count_post + CNT_W'(r_inflight);
  end

  // State registers; reset discards buffered and in-flight words.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_head     <= w_head_nxt;
      r_tail     <= w_tail_nxt;
      r_count    <= w_count_nxt;
      r_inflight <= w_ren;
    end
  end

  assign bus.ren       = w_ren;
  assign bus.out_data  = r_head;
  assign bus.out_valid = (r_count != CNT_W'(0));
  assign bus.level     = r_count;

endmodule

// File: tb/tb_fifo_read_stage.sv
// Directed bench for fifo_read_stage: a cycle table plus streaming/drain sequences.
module tb_fifo_read_stage;

  localparam int unsigned WIDTH = 8;
  localparam logic [WIDTH-1:0] JUNK = 8'hEE;

  logic clock;
  logic reset;

  fifo_read_stage_if #(.WIDTH(WIDTH)) bus ();

  fifo_read_stage #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic             rst;
    logic             empty;
    logic             rdy;
    logic [WIDTH-1:0] rd;
    logic             exp_ren;
    logic             exp_valid;
    logic [WIDTH-1:0] exp_data;
    logic [1:0]       exp_level;
  } vec_t;

  vec_t vecs[$];
  int   n_checks;
  int   n_fail;

  task automatic add(input logic rst, input logic empty, input logic rdy, input logic [WIDTH-1:0] rd,
                     input logic eren, input logic evalid, input logic [WIDTH-1:0] edata,
                     input logic [1:0] elevel);
    vec_t v;
    v.rst = rst; v.empty = empty; v.rdy = rdy; v.rd = rd;
    v.exp_ren = eren; v.exp_valid = evalid; v.exp_data = edata; v.exp_level = elevel;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Apply inputs just after the edge, check outputs on the falling edge, advance to next edge.
  task automatic cycle(input logic rst, input logic empty, input logic rdy, input logic [WIDTH-1:0] rd,
                       output logic ren_seen);
    reset         = rst;
    bus.empty     = empty;
    bus.out_ready = rdy;
    bus.rd_data   = rd;
    @(negedge clock);
    ren_seen = bus.ren;
  endtask

  task automatic next_edge();
    @(posedge clock);
    #1;
  endtask

  // Stream n words from a FIFO model with out_ready high; data values base..base+n-1.
  task automatic run_stream(input string tag, input int n, input logic [WIDTH-1:0] base);
    int               words_left;
    logic [WIDTH-1:0] next_val;
    logic             prev_ren;
    logic [WIDTH-1:0] ret_val;
    logic             ren_now;
    words_left = n;
    next_val   = base;
    prev_ren   = 1'b0;
    ret_val    = JUNK;
    for (int k = 0; k < n + 4; k++) begin
      cycle(1'b0, (words_left == 0), 1'b1, prev_ren ? ret_val : JUNK, ren_now);
      check({tag, "_ren"}, k, 32'(ren_now), 32'(k < n));
      check({tag, "_valid"}, k, 32'(bus.out_valid), 32'((k >= 2) && (k < n + 2)));
      if ((k >= 2) && (k < n + 2))
        check({tag, "_data"}, k, 32'(bus.out_data), 32'(base + WIDTH'(k - 2)));
      prev_ren = ren_now;
      if (ren_now) begin
        ret_val  = next_val;
        next_val = next_val + WIDTH'(1);
        if (words_left > 0) words_left--;
      end
      next_edge();
    end
    check({tag, "_level_end"}, n + 4, 32'(bus.level), 32'(0));
  endtask

  initial begin
    logic ren_now;
    n_checks = 0;
    n_fail   = 0;

    // rst empty rdy rd    ren valid data  level
    // Reset held with FIFO non-empty, then first read right after release.
    add(1, 0, 1, 8'h00, 0, 0, 8'h00, 2'd0);
    add(1, 0, 1, 8'h00, 0, 0, 8'h00, 2'd0);
    add(0, 0, 1, 8'h00, 1, 0, 8'h00, 2'd0);
    add(0, 1, 1, 8'h3C, 0, 0, 8'h00, 2'd0);
    add(0, 1, 1, JUNK,  0, 1, 8'h3C, 2'd1);
    add(0, 1, 1, JUNK,  0, 0, 8'h00, 2'd0);
    // Single word A5: ren in N, valid only in N+2.
    add(0, 0, 1, JUNK,  1, 0, 8'h00, 2'd0);
    add(0, 1, 1, 8'hA5, 0, 0, 8'h00, 2'd0);
    add(0, 1, 1, JUNK,  0, 1, 8'hA5, 2'd1);
    add(0, 1, 1, JUNK,  0, 0, 8'h00, 2'd0);
    // Backpressure: two reads then hold; one-cycle ready pops and reissues.
    add(0, 0, 0, JUNK,  1, 0, 8'h00, 2'd0);
    add(0, 0, 0, 8'hB1, 1, 0, 8'h00, 2'd0);
    add(0, 0, 0, 8'hB2, 0, 1, 8'hB1, 2'd1);
    add(0, 0, 0, JUNK,  0, 1, 8'hB1, 2'd2);
    add(0, 0, 0, JUNK,  0, 1, 8'hB1, 2'd2);
    add(0, 0, 1, JUNK,  1, 1, 8'hB1, 2'd2);
    add(0, 0, 0, 8'hB3, 0, 1, 8'hB2, 2'd1);
    add(0, 0, 0, JUNK,  0, 1, 8'hB2, 2'd2);
    add(0, 0, 1, JUNK,  1, 1, 8'hB2, 2'd2);
    // FIFO goes empty while a read is in flight and the buffer drains.
    add(0, 1, 1, 8'hB4, 0, 1, 8'hB3, 2'd1);
    add(0, 1, 1, JUNK,  0, 1, 8'hB4, 2'd1);
    add(0, 1, 1, JUNK,  0, 0, 8'h00, 2'd0);
    // Reset with buffered and in-flight words; stale returns must be ignored.
    add(0, 0, 0, JUNK,  1, 0, 8'h00, 2'd0);
    add(0, 0, 0, 8'hC1, 1, 0, 8'h00, 2'd0);
    add(0, 0, 0, 8'hC2, 0, 1, 8'hC1, 2'd1);
    add(0, 0, 1, JUNK,  1, 1, 8'hC1, 2'd2);
    add(1, 0, 0, 8'hC3, 0, 1, 8'hC2, 2'd1);
    add(0, 1, 1, 8'hC4, 0, 0, 8'h00, 2'd0);
    add(0, 1, 1, JUNK,  0, 0, 8'h00, 2'd0);

    reset         = 1'b1;
    bus.empty     = 1'b0;
    bus.out_ready = 1'b1;
    bus.rd_data   = '0;
    next_edge();

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].rst, vecs[i].empty, vecs[i].rdy, vecs[i].rd, ren_now);
      check("ren", i, 32'(ren_now), 32'(vecs[i].exp_ren));
      check("out_valid", i, 32'(bus.out_valid), 32'(vecs[i].exp_valid));
      check("level", i, 32'(bus.level), 32'(vecs[i].exp_level));
      if (vecs[i].exp_valid)
        check("out_data", i, 32'(bus.out_data), 32'(vecs[i].exp_data));
      next_edge();
    end

    run_stream("stream", 16, 8'h01);
    run_stream("drain", 3, 8'h51);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
